mem_lsu: RTL and testbench

Parametrised load/store unit replacing the fixed 16-bit MEM pipeline stage of the swt16 core. It sits between EX and WB and drives the DMEM port. DMEM is byte-addressed and DMEM_WORD_WIDTH wide, and accesses use a req/ack handshake with variable latency. The unit supports byte and word loads and stores on any lane, stalls the pipeline while DMEM is busy, and reports misaligned, illegal and timed-out accesses.

---
 rtl/mem_lsu.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit between EX and WB: drives a byte-addressed DMEM over a req/ack
// handshake, stalls upstream while the access is outstanding and reports faults.
module mem_lsu #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES  = 15,
    localparam int LANES          = DMEM_WORD_WIDTH / 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem_word,
    input  logic                       in_act_load_dmem_byte_signed,
    input  logic                       in_act_load_dmem_byte_unsigned,
    input  logic                       in_act_store_dmem_word,
    input  logic                       in_act_store_dmem_byte,
    input  logic                       in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic                       in_instr_is_bubble,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_wr_data,
    input  logic [DMEM_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_mem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
    output logic                       out_stall,
    output logic                       out_mem_req,
    output logic                       out_mem_write_en,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [LANES-1:0]           out_mem_byte_en,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                       out_act_write_res_to_reg,
    output logic [DMEM_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_instr_is_bubble,
    output logic [1:0]                 out_fault
);

    localparam int LB    = $clog2(LANES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd3;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DMEM_ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
    logic                       op_write_q, op_write_d;
    logic [LANES-1:0]           op_byte_en_q, op_byte_en_d;
    logic [DMEM_WORD_WIDTH-1:0] op_wr_word_q, op_wr_word_d;
    logic                       op_ld_word_q, op_ld_word_d;
    logic                       op_ld_signed_q, op_ld_signed_d;
    logic [DMEM_WORD_WIDTH-1:0] op_res_q, op_res_d;
    logic                       op_write_res_q, op_write_res_d;
    logic [REG_IDX_WIDTH-1:0]   op_reg_idx_q, op_reg_idx_d;
    logic [PMEM_WORD_WIDTH-1:0] op_instr_q, op_instr_d;
    logic [PC_WIDTH-1:0]        op_pc_q, op_pc_d;

    logic                       wb_write_q, wb_write_d;
    logic [DMEM_WORD_WIDTH-1:0] res_q, res_d;
    logic [REG_IDX_WIDTH-1:0]   reg_idx_q, reg_idx_d;
    logic [PMEM_WORD_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic                       bubble_q, bubble_d;
    logic [1:0]                 fault_q, fault_d;

    logic [2:0]                 act_cnt;
    logic                       active, mem_op, illegal, misaligned, legal;
    logic                       waiting, req, acked, timed_out, done;
    logic [LB-1:0]              lane;
    logic [7:0]                 rd_byte;
    logic [DMEM_WORD_WIDTH-1:0] load_val;

    // Decode the incoming op; while waiting, the latched fields stay the current op.
    always_comb begin
        act_cnt = 3'(in_act_load_dmem_word) + 3'(in_act_load_dmem_byte_signed)
                + 3'(in_act_load_dmem_byte_unsigned) + 3'(in_act_store_dmem_word)
                + 3'(in_act_store_dmem_byte);
        active     = !in_instr_is_bubble;
        mem_op     = active && (act_cnt == 3'd1);
        illegal    = active && (act_cnt > 3'd1);
        misaligned = mem_op && (in_act_load_dmem_word || in_act_store_dmem_word)
                     && (in_addr[LB-1:0] != '0);
        legal      = mem_op && !misaligned;
        waiting    = (state_q == S_WAIT);

        op_addr_d      = op_addr_q;
        op_write_d     = op_write_q;
        op_byte_en_d   = op_byte_en_q;
        op_wr_word_d   = op_wr_word_q;
        op_ld_word_d   = op_ld_word_q;
        op_ld_signed_d = op_ld_signed_q;
        op_res_d       = op_res_q;
        op_write_res_d = op_write_res_q;
        op_reg_idx_d   = op_reg_idx_q;
        op_instr_d     = op_instr_q;
        op_pc_d        = op_pc_q;
        if (!waiting) begin
            op_addr_d      = in_addr;
            op_write_d     = in_act_store_dmem_word || in_act_store_dmem_byte;
            op_ld_word_d   = in_act_load_dmem_word;
            op_ld_signed_d = in_act_load_dmem_byte_signed;
            op_res_d       = in_res;
            op_write_res_d = in_act_write_res_to_reg;
            op_reg_idx_d   = in_res_reg_idx;
            op_instr_d     = in_instr;
            op_pc_d        = in_pc;
            if (in_act_store_dmem_word) begin
                op_byte_en_d = '1;
                op_wr_word_d = in_wr_data;
            end else if (in_act_store_dmem_byte) begin
                op_byte_en_d = LANES'(1) << in_addr[LB-1:0];
                op_wr_word_d = {LANES{in_wr_data[7:0]}};
            end else begin
                op_byte_en_d = '0;
                op_wr_word_d = in_wr_data;
            end
        end
    end

    // Handshake, timeout and the value handed to WB at the next edge.
    always_comb begin
        req       = !reset && (waiting || legal);
        acked     = req && in_mem_ack;
        timed_out = TO_EN && req && !in_mem_ack && (cnt_q == TO_LAST);
        done      = acked || timed_out;

        lane     = op_addr_d[LB-1:0];
        rd_byte  = in_mem_rd_word[{lane, 3'b000} +: 8];
        load_val = op_ld_word_d ? in_mem_rd_word
                 : {{(DMEM_WORD_WIDTH-8){op_ld_signed_d & rd_byte[7]}}, rd_byte};

        state_d = state_q;
        if (!waiting && legal && !done) begin
            state_d = S_WAIT;
        end else if (waiting && done) begin
            state_d = S_IDLE;
        end

        cnt_d = '0;
        if (req && !done && TO_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        reg_idx_d = op_reg_idx_d;
        instr_d   = op_instr_d;
        pc_d      = op_pc_d;
        res_d     = op_res_d;
        if (waiting || legal) begin
            bubble_d   = !done;
            fault_d    = timed_out ? FAULT_TIMEOUT : FAULT_NONE;
            wb_write_d = done && op_write_res_d && !timed_out;
            if (acked && !op_write_d) begin
                res_d = load_val;
            end
        end else begin
            bubble_d   = in_instr_is_bubble;
            fault_d    = illegal ? FAULT_ILLEGAL : (misaligned ? FAULT_MISALIGN : FAULT_NONE);
            wb_write_d = in_act_write_res_to_reg && active && !illegal && !misaligned;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_addr_q      <= '0;
            op_write_q     <= 1'b0;
            op_byte_en_q   <= '0;
            op_wr_word_q   <= '0;
            op_ld_word_q   <= 1'b0;
            op_ld_signed_q <= 1'b0;
            op_res_q       <= '0;
            op_write_res_q <= 1'b0;
            op_reg_idx_q   <= '0;
            op_instr_q     <= '0;
            op_pc_q        <= '0;
            wb_write_q     <= 1'b0;
            res_q          <= '0;
            reg_idx_q      <= '0;
            instr_q        <= '0;
            pc_q           <= '0;
            bubble_q       <= 1'b1;
            fault_q        <= FAULT_NONE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_addr_q      <= op_addr_d;
            op_write_q     <= op_write_d;
            op_byte_en_q   <= op_byte_en_d;
            op_wr_word_q   <= op_wr_word_d;
            op_ld_word_q   <= op_ld_word_d;
            op_ld_signed_q <= op_ld_signed_d;
            op_res_q       <= op_res_d;
            op_write_res_q <= op_write_res_d;
            op_reg_idx_q   <= op_reg_idx_d;
            op_instr_q     <= op_instr_d;
            op_pc_q        <= op_pc_d;
            wb_write_q     <= wb_write_d;
            res_q          <= res_d;
            reg_idx_q      <= reg_idx_d;
            instr_q        <= instr_d;
            pc_q           <= pc_d;
            bubble_q       <= bubble_d;
            fault_q        <= fault_d;
        end
    end

    assign out_stall        = req && !done;
    assign out_mem_req      = req;
    assign out_mem_write_en = req && op_write_d;
    assign out_mem_addr     = req ? op_addr_d : '0;
    assign out_mem_byte_en  = req ? op_byte_en_d : '0;
    assign out_mem_wr_word  = req ? op_wr_word_d : '0;

    assign out_act_write_res_to_reg = wb_write_q;
    assign out_res                  = res_q;
    assign out_res_reg_idx          = reg_idx_q;
    assign out_instr                = instr_q;
    assign out_pc                   = pc_q;
    assign out_instr_is_bubble      = bubble_q;
    assign out_fault                = fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios followed by random ops,
// each compared against a transaction-level model of the load/store rules.
module tb_mem_lsu;

    localparam int T = 4;

    logic        clock;
    logic        reset;
    logic        in_act_load_dmem_word;
    logic        in_act_load_dmem_byte_signed;
    logic        in_act_load_dmem_byte_unsigned;
    logic        in_act_store_dmem_word;
    logic        in_act_store_dmem_byte;
    logic        in_act_write_res_to_reg;
    logic [15:0] in_instr;
    logic        in_instr_is_bubble;
    logic [11:0] in_pc;
    logic [11:0] in_addr;
    logic [15:0] in_wr_data;
    logic [15:0] in_res;
    logic [3:0]  in_res_reg_idx;
    logic        in_mem_ack;
    logic [15:0] in_mem_rd_word;
    logic        out_stall;
    logic        out_mem_req;
    logic        out_mem_write_en;
    logic [11:0] out_mem_addr;
    logic [1:0]  out_mem_byte_en;
    logic [15:0] out_mem_wr_word;
    logic        out_act_write_res_to_reg;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic [15:0] out_instr;
    logic [11:0] out_pc;
    logic        out_instr_is_bubble;
    logic [1:0]  out_fault;

    int errors = 0;
    int checks = 0;

    mem_lsu #(
        .DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .PC_WIDTH(12),
        .PMEM_WORD_WIDTH(16), .REG_IDX_WIDTH(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset),
        .in_act_load_dmem_word(in_act_load_dmem_word),
        .in_act_load_dmem_byte_signed(in_act_load_dmem_byte_signed),
        .in_act_load_dmem_byte_unsigned(in_act_load_dmem_byte_unsigned),
        .in_act_store_dmem_word(in_act_store_dmem_word),
        .in_act_store_dmem_byte(in_act_store_dmem_byte),
        .in_act_write_res_to_reg(in_act_write_res_to_reg),
        .in_instr(in_instr), .in_instr_is_bubble(in_instr_is_bubble), .in_pc(in_pc),
        .in_addr(in_addr), .in_wr_data(in_wr_data), .in_res(in_res),
        .in_res_reg_idx(in_res_reg_idx), .in_mem_ack(in_mem_ack),
        .in_mem_rd_word(in_mem_rd_word),
        .out_stall(out_stall), .out_mem_req(out_mem_req),
        .out_mem_write_en(out_mem_write_en), .out_mem_addr(out_mem_addr),
        .out_mem_byte_en(out_mem_byte_en), .out_mem_wr_word(out_mem_wr_word),
        .out_act_write_res_to_reg(out_act_write_res_to_reg), .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx), .out_instr(out_instr), .out_pc(out_pc),
        .out_instr_is_bubble(out_instr_is_bubble), .out_fault(out_fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // acts bit order: {store_byte, store_word, load_byte_unsigned, load_byte_signed, load_word}
    task automatic applyStimulus(input logic [4:0] acts, input bit bubble, input logic [11:0] addr,
                                 input logic [15:0] wrData, input logic [15:0] res, input bit wres);
        in_act_load_dmem_word          = acts[0];
        in_act_load_dmem_byte_signed   = acts[1];
        in_act_load_dmem_byte_unsigned = acts[2];
        in_act_store_dmem_word         = acts[3];
        in_act_store_dmem_byte         = acts[4];
        in_instr_is_bubble             = bubble;
        in_addr                        = addr;
        in_wr_data                     = wrData;
        in_res                         = res;
        in_act_write_res_to_reg        = wres;
        in_res_reg_idx                 = 4'($urandom);
        in_instr                       = 16'($urandom);
        in_pc                          = 12'($urandom);
        in_mem_ack                     = 1'b0;
    endtask

    // Runs the op currently on the inputs to completion; ackDelay < 0 means DMEM never answers.
    task automatic runOp(input string tag, input int ackDelay, input logic [15:0] rdWord);
        logic [4:0]  acts;
        int          lane, finalCycle, faultExp, b;
        bit          isMem, legal, isWord, isStore, completes, writeExp;
        logic [15:0] resExp, wrExp;
        acts    = {in_act_store_dmem_byte, in_act_store_dmem_word, in_act_load_dmem_byte_unsigned,
                   in_act_load_dmem_byte_signed, in_act_load_dmem_word};
        lane    = int'(in_addr) % 2;
        isWord  = acts[0] || acts[3];
        isStore = acts[3] || acts[4];
        isMem   = !in_instr_is_bubble && ($countones(acts) == 1);
        faultExp = 0;
        if (!in_instr_is_bubble && $countones(acts) > 1) faultExp = 3;
        else if (isMem && isWord && lane != 0) faultExp = 1;
        legal     = isMem && (faultExp == 0);
        completes = legal && ackDelay >= 0 && ackDelay < T;
        finalCycle = legal ? (completes ? ackDelay : T - 1) : 0;
        if (legal && !completes) faultExp = 2;

        resExp = in_res;
        if (completes && !isStore) begin
            b = (int'(rdWord) >> (8 * lane)) & 255;
            if (acts[0]) resExp = rdWord;
            else if (acts[1] && b >= 128) resExp = 16'(b + 65280);
            else resExp = 16'(b);
        end
        writeExp = in_act_write_res_to_reg && !in_instr_is_bubble && faultExp == 0;
        wrExp = acts[4] ? 16'(((int'(in_wr_data) & 255) * 257)) : in_wr_data;

        for (int c = 0; c <= finalCycle; c++) begin
            in_mem_ack     = legal && (c == ackDelay);
            in_mem_rd_word = (c == ackDelay) ? rdWord : 16'($urandom);
            #3;
            checkOutput({tag, ".req"}, 32'(out_mem_req), 32'(legal));
            checkOutput({tag, ".stall"}, 32'(out_stall), 32'(legal && c != finalCycle));
            if (legal && c == 0) begin
                checkOutput({tag, ".wen"}, 32'(out_mem_write_en), 32'(isStore));
                checkOutput({tag, ".addr"}, 32'(out_mem_addr), 32'(in_addr));
                checkOutput({tag, ".ben"}, 32'(out_mem_byte_en),
                            acts[3] ? 32'd3 : (acts[4] ? (32'd1 << lane) : 32'd0));
                if (isStore) checkOutput({tag, ".wword"}, 32'(out_mem_wr_word), 32'(wrExp));
            end
            @(posedge clock);
            #1;
            if (c != finalCycle) begin
                checkOutput({tag, ".wbBubble"}, 32'(out_instr_is_bubble), 32'd1);
                checkOutput({tag, ".wbWrite"}, 32'(out_act_write_res_to_reg), 32'd0);
                checkOutput({tag, ".wbFault"}, 32'(out_fault), 32'd0);
            end
        end
        in_mem_ack = 1'b0;
        checkOutput({tag, ".bubble"}, 32'(out_instr_is_bubble), 32'(in_instr_is_bubble));
        checkOutput({tag, ".fault"}, 32'(out_fault), 32'(faultExp));
        checkOutput({tag, ".res"}, 32'(out_res), 32'(resExp));
        checkOutput({tag, ".write"}, 32'(out_act_write_res_to_reg), 32'(writeExp));
        checkOutput({tag, ".idx"}, 32'(out_res_reg_idx), 32'(in_res_reg_idx));
        checkOutput({tag, ".instr"}, 32'(out_instr), 32'(in_instr));
        checkOutput({tag, ".pc"}, 32'(out_pc), 32'(in_pc));
    endtask

    initial begin
        logic [4:0] acts;
        int         x, y, r, d;
        bit         bub;

        reset = 1'b1;
        applyStimulus(5'b00000, 1'b1, 12'h000, 16'h0000, 16'h0000, 1'b0);
        in_mem_rd_word = 16'h0000;
        #2;
        checkOutput("rst.req", 32'(out_mem_req), 32'd0);
        checkOutput("rst.stall", 32'(out_stall), 32'd0);
        checkOutput("rst.bubble", 32'(out_instr_is_bubble), 32'd1);
        checkOutput("rst.res", 32'(out_res), 32'd0);
        checkOutput("rst.fault", 32'(out_fault), 32'd0);
        checkOutput("rst.write", 32'(out_act_write_res_to_reg), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(5'b00010, 1'b0, 12'h013, 16'h0000, 16'h5555, 1'b1);
        runOp("lbsZeroWait", 0, 16'h807F);
        applyStimulus(5'b10000, 1'b0, 12'h021, 16'h00AB, 16'h1111, 1'b0);
        runOp("sbZeroWait", 0, 16'h0000);
        applyStimulus(5'b00001, 1'b0, 12'h040, 16'h0000, 16'h2222, 1'b1);
        runOp("lwAck3", 3, 16'h1234);
        applyStimulus(5'b00000, 1'b0, 12'h000, 16'h0000, 16'h3333, 1'b1);
        runOp("addAfterLw", -1, 16'h0000);
        applyStimulus(5'b00001, 1'b0, 12'h005, 16'h0000, 16'h4444, 1'b1);
        runOp("lwMisaligned", 0, 16'hBEEF);
        applyStimulus(5'b00101, 1'b0, 12'h010, 16'h0000, 16'h6666, 1'b1);
        runOp("illegalCombo", 0, 16'hBEEF);
        applyStimulus(5'b00001, 1'b0, 12'h062, 16'h0000, 16'h7777, 1'b1);
        runOp("lwTimeout", -1, 16'h0000);
        applyStimulus(5'b00000, 1'b1, 12'h000, 16'h0000, 16'h8888, 1'b0);
        runOp("bubbleAfterTimeout", -1, 16'h0000);
        applyStimulus(5'b01000, 1'b0, 12'h0A4, 16'hCAFE, 16'h9999, 1'b0);
        runOp("swAfterTimeout", 1, 16'h0000);

        // Abandon a store stuck in WAIT with an asynchronous reset.
        applyStimulus(5'b01000, 1'b0, 12'h0B0, 16'hD00D, 16'hAAAA, 1'b1);
        #3;
        checkOutput("waitEntry.stall", 32'(out_stall), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rstInWait.req", 32'(out_mem_req), 32'd0);
        checkOutput("rstInWait.stall", 32'(out_stall), 32'd0);
        checkOutput("rstInWait.wen", 32'(out_mem_write_en), 32'd0);
        checkOutput("rstInWait.bubble", 32'(out_instr_is_bubble), 32'd1);
        checkOutput("rstInWait.res", 32'(out_res), 32'd0);
        @(posedge clock);
        #1;
        applyStimulus(5'b00100, 1'b0, 12'h0C0, 16'h0000, 16'hBBBB, 1'b1);
        reset = 1'b0;
        runOp("lbuAfterReset", 0, 16'h1280);

        $display("[TB] random ops");
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            x = $urandom_range(0, 4);
            y = (x + $urandom_range(1, 4)) % 5;
            bub = ($urandom_range(0, 7) == 0);
            acts = 5'b00001 << x;
            if (r == 0) acts = 5'b00000;
            if (r == 1) acts = (5'b00001 << x) | (5'b00001 << y);
            if (bub) acts = 5'b00000;
            d = $urandom_range(0, 6) - 1;
            applyStimulus(acts, bub, 12'($urandom), 16'($urandom), 16'($urandom),
                          bub ? 1'b0 : 1'($urandom));
            runOp("random", d, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
